// File: rtl/comb_logic_pkg.sv
// comb_logic_pkg: shared constants and per-bit gate-network functions for comb_logic_pipe
// Ports: none (package). eval_x/eval_y work on a single bit; callers apply them across
// any vector width, which keeps them WIDTH-generic.
package comb_logic_pkg;
    localparam int STATS_W = 16;

    function automatic logic eval_x(input logic a, input logic b, input logic c);
        return ~c ^ (a | b);
    endfunction

    // The original lab network; it reduces to a & b.
    function automatic logic eval_y(input logic a, input logic b);
        return (~(a & b) ^ (a | b)) & (a | b);
    endfunction
endpackage

// File: rtl/comb_logic_pipe_if.sv
// comb_logic_pipe_if: operand/result handshake bundle for comb_logic_pipe
// Ports: in_valid/in_ready/a/b/c (operand side), out_valid/out_ready/x/y (result side),
// level (FIFO occupancy). slave = design view, master = driver/consumer view.
interface comb_logic_pipe_if #(parameter int WIDTH = 8, parameter int DEPTH = 4);
    logic in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] a, b, c, x, y;
    logic [$clog2(DEPTH):0] level;
    modport master(output in_valid, a, b, c, out_ready, input in_ready, out_valid, x, y, level);
    modport slave(input in_valid, a, b, c, out_ready, output in_ready, out_valid, x, y, level);
endinterface

// File: rtl/comb_logic_fifo.sv
// comb_logic_fifo: DEPTH-entry synchronous FIFO with fully registered outputs
// Ports: clk, reset (sync, active-high); i_valid/o_in_ready push handshake with i_data;
// o_out_valid/i_ready pop handshake with o_data (registered head); o_level occupancy.
module comb_logic_fifo #(
    parameter int DEPTH = 4,
    parameter type T = logic
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_valid,
    input  logic                   i_ready,
    input  T                       i_data,
    output logic                   o_in_ready,
    output logic                   o_out_valid,
    output T                       o_data,
    output logic [$clog2(DEPTH):0] o_level
);
    localparam int AW = $clog2(DEPTH);
    T r_mem [DEPTH];
    T r_head, w_head_n;
    logic [AW-1:0] r_wr, r_rd, w_rd_n;
    logic [AW:0] r_cnt, w_cnt_n;
    logic r_in_ready, r_out_valid, w_push, w_pop;
    always_comb begin
        w_push = i_valid & r_in_ready;
        w_pop = r_out_valid & i_ready;
        w_cnt_n = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        w_rd_n = r_rd + AW'(w_pop);
        // Head is prefetched: when the FIFO would otherwise drain this cycle, the incoming
        // word becomes the head directly; going empty keeps the last head value.
        w_head_n = (w_cnt_n == '0) ? r_head : (r_cnt == (AW+1)'(w_pop)) ? i_data : r_mem[w_rd_n];
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr <= '0;
            r_rd <= '0;
            r_cnt <= '0;
            r_head <= '0;
            r_in_ready <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_wr <= r_wr + AW'(w_push);
            r_rd <= w_rd_n;
            r_cnt <= w_cnt_n;
            r_head <= w_head_n;
            r_in_ready <= w_cnt_n != (AW+1)'(DEPTH);
            r_out_valid <= w_cnt_n != '0;
        end
    end
    assign o_in_ready = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_data = r_head;
    assign o_level = r_cnt;
endmodule

// File: rtl/comb_logic_pipe.sv
// comb_logic_pipe: pipelined bitwise x = ~c ^ (a | b), y = a & b with an output FIFO
// Ports: clk, reset (sync, active-high); bus (comb_logic_pipe_if.slave) carries the
// operand/result handshakes and level. Optional macro CLP_STATS_EN adds stats_clr input
// and stats_acc/stats_hit saturating counters; without it those ports do not exist.
module comb_logic_pipe
    import comb_logic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
`ifdef CLP_STATS_EN
    input  logic               stats_clr,
    output logic [STATS_W-1:0] stats_acc,
    output logic [STATS_W-1:0] stats_hit,
`endif
    comb_logic_pipe_if.slave   bus
);
    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
    } result_t;
    result_t w_res, w_head;
    always_comb begin
        w_res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_res.x[i] = eval_x(bus.a[i], bus.b[i], bus.c[i]);
            w_res.y[i] = eval_y(bus.a[i], bus.b[i]);
        end
    end
    comb_logic_fifo #(.DEPTH(DEPTH), .T(result_t)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_valid     (bus.in_valid),
        .i_ready     (bus.out_ready),
        .i_data      (w_res),
        .o_in_ready  (bus.in_ready),
        .o_out_valid (bus.out_valid),
        .o_data      (w_head),
        .o_level     (bus.level)
    );
    assign bus.x = w_head.x;
    assign bus.y = w_head.y;
`ifdef CLP_STATS_EN
    logic w_acc;
    logic [STATS_W-1:0] r_acc, r_hit;
    assign w_acc = bus.in_valid & bus.in_ready;
    always_ff @(posedge clk) begin
        if (reset || stats_clr) begin
            r_acc <= '0;
            r_hit <= '0;
        end else if (w_acc) begin
            if (r_acc != '1) r_acc <= r_acc + STATS_W'(1);
            if (w_res.y != '0 && r_hit != '1) r_hit <= r_hit + STATS_W'(1);
        end
    end
    assign stats_acc = r_acc;
    assign stats_hit = r_hit;
`endif
endmodule

// File: tb/tb_comb_logic_pipe.sv
// tb_comb_logic_pipe: randomized and directed self-checking bench for comb_logic_pipe
module tb_comb_logic_pipe;
    localparam int W = 8;
    localparam int D = 4;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    comb_logic_pipe_if #(.WIDTH(W), .DEPTH(D)) bus();
`ifdef CLP_STATS_EN
    logic stats_clr;
    logic [15:0] stats_acc, stats_hit;
    comb_logic_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .stats_clr(stats_clr),
        .stats_acc(stats_acc), .stats_hit(stats_hit), .bus(bus));
    int unsigned m_acc, m_hit;
`else
    comb_logic_pipe #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif
    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
    } res_t;
    res_t q[$];
    logic [W-1:0] last_x, last_y;
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic [W-1:0] ic, input logic ordy,
                        input logic rst_i = 1'b0, input logic clr = 1'b0);
        logic push, pop;
        res_t r;
        bus.in_valid = v;
        bus.a = ia;
        bus.b = ib;
        bus.c = ic;
        bus.out_ready = ordy;
        reset = rst_i;
`ifdef CLP_STATS_EN
        stats_clr = clr;
`endif
        #1;
        check("in_ready", bus.in_ready, q.size() != D);
        check("out_valid", bus.out_valid, q.size() != 0);
        check("level", bus.level, q.size());
        check("x", bus.x, q.size() != 0 ? q[0].x : last_x);
        check("y", bus.y, q.size() != 0 ? q[0].y : last_y);
`ifdef CLP_STATS_EN
        check("stats_acc", stats_acc, m_acc);
        check("stats_hit", stats_hit, m_hit);
`endif
        r.x = ~ic ^ (ia | ib);
        r.y = (~(ia & ib) ^ (ia | ib)) & (ia | ib);
        push = !rst_i && v && q.size() != D;
        pop = !rst_i && ordy && q.size() != 0;
        @(posedge clk);
        if (rst_i) begin
            q.delete();
            last_x = '0;
            last_y = '0;
`ifdef CLP_STATS_EN
            m_acc = 0;
            m_hit = 0;
`endif
        end else begin
            if (pop) begin
                last_x = q[0].x;
                last_y = q[0].y;
                void'(q.pop_front());
            end
            if (push) q.push_back(r);
`ifdef CLP_STATS_EN
            if (clr) begin
                m_acc = 0;
                m_hit = 0;
            end else if (push) begin
                if (m_acc < 32'hFFFF) m_acc++;
                if (r.y != 0 && m_hit < 32'hFFFF) m_hit++;
            end
`endif
        end
        @(negedge clk);
    endtask

    task automatic rnd(input logic v, input logic ordy);
        step(v, W'($urandom), W'($urandom), W'($urandom), ordy);
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.c = '0;
`ifdef CLP_STATS_EN
        stats_clr = 1'b0;
        m_acc = 0;
        m_hit = 0;
`endif
        last_x = '0;
        last_y = '0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_level", bus.level, 0);
        check("rst_x", bus.x, 0);
        check("rst_y", bus.y, 0);

        step(1'b1, 8'hF0, 8'hCC, 8'hAA, 1'b1);
        check("basic_valid", bus.out_valid, 1);
        check("basic_x", bus.x, 32'hA9);
        check("basic_y", bus.y, 32'hC0);
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        check("basic_level", bus.level, 0);

        step(1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
        check("zero_x", bus.x, 32'hFF);
        check("zero_y", bus.y, 32'h00);
        step(1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b1);
        check("ones_x", bus.x, 32'hFF);
        check("ones_y", bus.y, 32'hFF);
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);

        for (int i = 0; i < 6; i++) rnd(1'b1, 1'b0);
        check("bp_level", bus.level, 4);
        check("bp_in_ready", bus.in_ready, 0);
        for (int i = 0; i < 5; i++) rnd(1'b0, 1'b1);
        check("bp_drained", bus.level, 0);

        rnd(1'b1, 1'b0);
        rnd(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) rnd(1'b1, 1'b1);
        check("pp_level", bus.level, 2);
        for (int i = 0; i < 3; i++) rnd(1'b0, 1'b1);

        for (int i = 0; i < 3; i++) rnd(1'b1, 1'b0);
        check("pre_rst_level", bus.level, 3);
        step(1'b1, 8'h5A, 8'hA5, 8'h3C, 1'b1, 1'b1);
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_level", bus.level, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 3; i++) rnd(1'b0, 1'b1);

        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), W'($urandom),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 39) == 0);

`ifdef CLP_STATS_EN
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
        step(1'b1, 8'h00, 8'hFF, 8'h12, 1'b1);
        step(1'b1, 8'h01, 8'h01, 8'h34, 1'b1);
        step(1'b1, 8'h80, 8'hFF, 8'h56, 1'b1);
        check("st_acc3", stats_acc, 3);
        check("st_hit2", stats_hit, 2);
        for (int i = 0; i < 65540; i++) step(1'b1, 8'hFF, 8'hFF, 8'h00, 1'b1);
        check("st_acc_sat", stats_acc, 32'hFFFF);
        check("st_hit_sat", stats_hit, 32'hFFFF);
        step(1'b1, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
        check("st_clr_acc", stats_acc, 0);
        check("st_clr_hit", stats_hit, 0);
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/comb_logic_pipe.md
Name: comb_logic_pipe

Overview:
- Parametrised, pipelined successor to the lab 3 a/b/c → x/y gate network.
- Evaluates the same logic bitwise on WIDTH-bit vectors:
  - x = ~c ^ (a | b)
  - y = (~(a & b) ^ (a | b)) & (a | b), which reduces to a & b
- Input and output use valid/ready handshakes.
- Results are buffered in a DEPTH-entry output FIFO, so upstream is not stalled by short downstream back-pressure.
- Sits between the lab stimulus source and the display/checker logic.

Parameters:
- WIDTH, 8, bit width of the a, b, c, x and y vectors (>= 1).
- DEPTH, 4, output FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  a/b/c operands valid.
- in_ready  output  1  block can accept an operand set this cycle.
- a  input  WIDTH  operand a.
- b  input  WIDTH  operand b.
- c  input  WIDTH  operand c.
- out_valid  output  1  x/y result valid at FIFO head.
- out_ready  input  1  downstream accepts the result.
- x  output  WIDTH  result x at FIFO head.
- y  output  WIDTH  result y at FIFO head.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Single clock domain (clk); reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values:
  - in_ready = 1 (reset deasserted), out_valid = 0, x = 0, y = 0, level = 0.
  - Read pointer, write pointer and count are all 0.
- Accept (push): in_valid & in_ready at a clk edge.
  - x/y are computed combinationally from a/b/c.
  - The result is written to the FIFO entry at the write pointer.
  - The write pointer advances modulo DEPTH.
- Pop: out_valid & out_ready at a clk edge.
  - The read pointer advances modulo DEPTH.
- Output timing:
  - x/y are driven from the registered FIFO head.
  - out_valid = (count != 0), driven from a register.
  - Latency from accept to out_valid is 1 cycle when the FIFO is empty.
  - There is no combinational input-to-output path.
- in_ready = (count != DEPTH), registered.
  - When the FIFO is full, in_ready stays low even if a pop happens in the same cycle; there is no full-bypass.
- Count update per cycle:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, both pointers advance.
- Empty FIFO: out_ready is ignored, pointers do not move, and x/y hold their last value.
- Full FIFO: in_valid is ignored and no entry is overwritten.
- Pointer wrap-around is natural modulo-DEPTH; count disambiguates full from empty.
- Reset during activity: all entries are discarded on the reset edge and outputs go to reset values the next cycle. Data presented while reset is high is never accepted.
- Handshake stability:
  - Once out_valid is high, x/y stay stable until popped.
  - Upstream may change a/b/c freely while in_valid is low.
- level equals count and is registered.

Optional Feature:
- Macro: CLP_STATS_EN.
- Defined:
  - Adds input stats_clr (1) and outputs stats_acc (16) and stats_hit (16).
  - stats_acc counts accepted operand sets.
  - stats_hit counts accepted sets whose computed y is nonzero.
  - Both counters saturate at 16'hFFFF and reset to 0.
  - stats_clr zeroes both counters on the next edge; clear has priority over a same-cycle increment.
- Undefined: these ports and the counter logic do not exist; all other behaviour is identical.

Decomposition:
- Package comb_logic_pkg:
  - function eval_x(a, b, c) and function eval_y(a, b), both WIDTH-generic via parameterised typedef or unbounded logic.
  - typedef struct result_t {x, y}.
  - localparam STATS_W = 16.
- Sub-module comb_logic_fifo:
  - generic DEPTH × result_t synchronous FIFO holding pointers, count, registered out_valid/in_ready and level.
- Top-level comb_logic_pipe instantiates the FIFO and the eval logic, and holds the optional stats counters.

Test Plan:
- Basic evaluation (WIDTH=8), a=8'hF0, b=8'hCC, c=8'hAA, single accept with out_ready=1 → out_valid high 1 cycle later with x=8'hA9, y=8'hC0, level returning to 0 after the pop.
- All-zero operands, a=b=c=0 → x=8'hFF, y=8'h00; a=b=c=8'hFF → x=8'hFF, y=8'hFF.
- Back-pressure (DEPTH=4), out_ready=0 with 6 consecutive valid inputs → exactly 4 accepted, in_ready low from the cycle after the 4th accept, level=4, no overwrite. Then out_ready=1 drains the 4 results in order, and in_ready reasserts the cycle after the first pop.
- Simultaneous push/pop at level=2 for 10 cycles → level stays 2, results emerge in FIFO order, pointers wrap correctly past DEPTH.
- Reset mid-operation with level=3, reset high for 1 cycle → next cycle out_valid=0, level=0, in_ready=1; a previously queued result never appears.
- CLP_STATS_EN: accept 3 sets with y = 8'h00, 8'h01, 8'h80 → stats_acc=3, stats_hit=2. Preload near saturation and verify the hold at 16'hFFFF; stats_clr concurrent with an accept → both counters 0.
